// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit feeder: byte width, launcher
// state encoding and the defensive arm timeout.
package uart_pkg;

    localparam int BYTE_W      = 8;
    localparam int ARM_TIMEOUT = 4;
    localparam int ARM_W       = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

    // Launcher states; kept as plain constants so older netlists that
    // compare raw 2-bit codes keep working.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-side signal bundle of the UART transmit feeder.
// The slave modport is the feeder; the master side is producer plus transmitter.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);

    byte_t         wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          ovf_clr;
    logic          flush;
    byte_t         tx_din;
    logic          tx_wen;
    logic          tx_busy;
    logic          idle;

    modport master (
        output wr_data, wr_en, ovf_clr, flush, tx_busy,
        input  full, empty, count, overflow, tx_din, tx_wen, idle
    );

    modport slave (
        input  wr_data, wr_en, ovf_clr, flush, tx_busy,
        output full, empty, count, overflow, tx_din, tx_wen, idle
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x BYTE_W byte store: synchronous write, asynchronous read so the
// launcher can capture the head byte in the same cycle it pops.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  byte_t         wdata,
    input  logic [AW-1:0] raddr,
    output byte_t         rdata
);

    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers producer bursts and launches
// one byte per transmitter busy cycle through a small launcher FSM.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_fifo_if.slave bus
);

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic [1:0]       state_reg;
    logic [ARM_W-1:0] arm_cnt_reg;
    byte_t            tx_din_reg;
    logic             tx_wen_reg;
    byte_t            rd_data;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Occupancy flags come from the count, never from pointer comparison.
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);

    // full is the pre-edge value, so a write while full is dropped even if
    // the launcher pops on the same edge.
    assign push = bus.wr_en && !full && !bus.flush;
    assign pop  = (state_reg == S_IDLE) && !empty && !bus.tx_busy && !bus.flush;

    always_comb begin
        count_next = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Set dominates clear so a drop in the clearing cycle is not lost.
    always_comb begin
        overflow_next = overflow_reg;
        if (bus.wr_en && full) begin
            overflow_next = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_reg),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= overflow_next;
            if (bus.flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                count_reg <= count_next;
            end
        end
    end

    // Launcher. The transmitter raises busy one cycle after wen, so S_ARM
    // bridges that gap and gives up after ARM_TIMEOUT cycles if busy never comes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            arm_cnt_reg <= '0;
            tx_din_reg  <= '0;
            tx_wen_reg  <= 1'b0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    tx_wen_reg <= 1'b0;
                    if (pop) begin
                        tx_din_reg  <= rd_data;
                        tx_wen_reg  <= 1'b1;
                        arm_cnt_reg <= '0;
                        state_reg   <= S_ARM;
                    end
                end
                S_ARM: begin
                    tx_wen_reg <= 1'b0;
                    if (bus.tx_busy) begin
                        state_reg <= S_WAIT;
                    end else if (arm_cnt_reg == ARM_W'(ARM_TIMEOUT - 1)) begin
                        state_reg <= S_IDLE;
                    end else begin
                        arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
                    end
                end
                S_WAIT: begin
                    tx_wen_reg <= 1'b0;
                    if (!bus.tx_busy) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    tx_wen_reg <= 1'b0;
                    state_reg  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_reg;
    assign bus.overflow = overflow_reg;
    assign bus.tx_din   = tx_din_reg;
    assign bus.tx_wen   = tx_wen_reg;
    assign bus.idle     = empty && (state_reg == S_IDLE) && !bus.tx_busy;

endmodule
